// File: rtl/sha256_block_padder_if.sv
// sha256_block_padder_if: memory read port plus padded-block handshake.
// master = padder side, slave = memory/consumer side.
interface sha256_block_padder_if #(
  parameter int unsigned ADDR_W = 16
);
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_read_data;
  logic              block_valid;
  logic              block_ready;
  logic [511:0]      block_data;
  logic              block_last;

  modport master (
    output mem_addr, block_valid, block_data, block_last,
    input  mem_read_data, block_ready
  );

  modport slave (
    input  mem_addr, block_valid, block_data, block_last,
    output mem_read_data, block_ready
  );
endinterface

// File: rtl/sha256_block_padder.sv
// sha256_block_padder: reads a byte-sized message from word-addressed memory and presents
// SHA-256 padded 512-bit blocks (0x80 delimiter, zero fill, 64-bit bit length) one at a time.
// Optional feature: define SHA256_PAD_BYTESWAP_EN to byte-swap each memory word before
// masking/padding (little-endian message storage).
module sha256_block_padder #(
  parameter int unsigned READ_LAT = 2,
  parameter int unsigned ADDR_W   = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  start_i,
  input  logic [31:0]           message_addr_i,
  input  logic [31:0]           size_i,
  output logic                  busy_o,
  output logic                  done_o,
  sha256_block_padder_if.master bus_if
);

  typedef enum logic [1:0] {StIdle, StFill, StPresent, StDone} state_e;

  state_e            state_q;
  logic [31:0]       size_q;
  logic [ADDR_W-1:0] base_q;
  logic [27:0]       nblocks_q;
  logic [31:0]       rd_words_q;
  logic [27:0]       blk_q;
  logic [4:0]        slot_q;       // next slot to process; 16 = all issued
  logic [ADDR_W-1:0] mem_addr_q;
  logic [511:0]      block_q;
  logic              block_valid_q;
  logic              block_last_q;
  logic              busy_q;
  logic              done_q;

  // Read tags: destination slot and mask kind (0 = whole word, 1..3 = bytes kept before 0x80)
  logic [READ_LAT-1:0] tag_vld_q;
  logic [3:0]          tag_slot_q [READ_LAT];
  logic [1:0]          tag_kind_q [READ_LAT];

  logic [31:0] k_w;
  logic [33:0] byte_pos;
  logic        is_read;
  logic [1:0]  kind;
  logic        last_blk;
  logic [31:0] pad_word;
  logic [31:0] rd_word;
  logic [31:0] rd_masked;
  logic        unused_addr;

  assign unused_addr = ^message_addr_i[31:ADDR_W];

  // Classify the slot currently being issued and form its non-memory value.
  always_comb begin
    k_w      = {blk_q[27:0], slot_q[3:0]};
    byte_pos = {k_w, 2'b00};
    is_read  = k_w < rd_words_q;
    kind     = ((byte_pos + 34'd4) <= {2'b00, size_q}) ? 2'd0 : size_q[1:0];
    last_blk = blk_q == (nblocks_q - 28'd1);
    pad_word = 32'h0;
    if (byte_pos == {2'b00, size_q}) begin
      pad_word = 32'h8000_0000;
    end else if (last_blk && slot_q[3:0] == 4'd14) begin
      pad_word = {29'd0, size_q[31:29]};
    end else if (last_blk && slot_q[3:0] == 4'd15) begin
      pad_word = {size_q[28:0], 3'b000};
    end
  end

  // Returning memory word: optional byte swap, then delimiter insertion for the partial word.
  always_comb begin
`ifdef SHA256_PAD_BYTESWAP_EN
    rd_word = {bus_if.mem_read_data[7:0], bus_if.mem_read_data[15:8],
               bus_if.mem_read_data[23:16], bus_if.mem_read_data[31:24]};
`else
    rd_word = bus_if.mem_read_data;
`endif
    rd_masked = rd_word;
    unique case (tag_kind_q[READ_LAT-1])
      2'd1:    rd_masked = (rd_word & 32'hFF00_0000) | 32'h0080_0000;
      2'd2:    rd_masked = (rd_word & 32'hFFFF_0000) | 32'h0000_8000;
      2'd3:    rd_masked = (rd_word & 32'hFFFF_FF00) | 32'h0000_0080;
      default: rd_masked = rd_word;
    endcase
  end

  // Control FSM, read-tag pipeline and block assembly register.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q       <= StIdle;
      size_q        <= '0;
      base_q        <= '0;
      nblocks_q     <= '0;
      rd_words_q    <= '0;
      blk_q         <= '0;
      slot_q        <= '0;
      mem_addr_q    <= '0;
      block_q       <= '0;
      block_valid_q <= 1'b0;
      block_last_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      tag_vld_q     <= '0;
      for (int unsigned i = 0; i < READ_LAT; i++) begin
        tag_slot_q[i] <= '0;
        tag_kind_q[i] <= '0;
      end
    end else begin
      tag_vld_q[0] <= 1'b0;
      for (int unsigned i = 1; i < READ_LAT; i++) begin
        tag_vld_q[i]  <= tag_vld_q[i-1];
        tag_slot_q[i] <= tag_slot_q[i-1];
        tag_kind_q[i] <= tag_kind_q[i-1];
      end
      if (tag_vld_q[READ_LAT-1]) begin
        block_q[{~tag_slot_q[READ_LAT-1], 5'd0} +: 32] <= rd_masked;
      end

      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            size_q     <= size_i;
            base_q     <= message_addr_i[ADDR_W-1:0];
            nblocks_q  <= 28'((33'(size_i) + 33'd72) >> 6);
            rd_words_q <= 32'((33'(size_i) + 33'd3) >> 2);
            blk_q      <= '0;
            slot_q     <= '0;
            busy_q     <= 1'b1;
            state_q    <= StFill;
          end
        end
        StFill: begin
          if (slot_q != 5'd16) begin
            if (is_read) begin
              mem_addr_q    <= base_q + k_w[ADDR_W-1:0];
              tag_vld_q[0]  <= 1'b1;
              tag_slot_q[0] <= slot_q[3:0];
              tag_kind_q[0] <= kind;
            end else begin
              block_q[{~slot_q[3:0], 5'd0} +: 32] <= pad_word;
            end
            slot_q <= slot_q + 5'd1;
          end else if (!(|tag_vld_q)) begin
            // Every slot was written on an earlier edge.
            block_valid_q <= 1'b1;
            block_last_q  <= last_blk;
            state_q       <= StPresent;
          end
        end
        StPresent: begin
          if (bus_if.block_ready) begin
            block_valid_q <= 1'b0;
            block_last_q  <= 1'b0;
            if (block_last_q) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= StDone;
            end else begin
              blk_q   <= blk_q + 28'd1;
              slot_q  <= '0;
              state_q <= StFill;
            end
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_if.mem_addr    = mem_addr_q;
  assign bus_if.block_valid = block_valid_q;
  assign bus_if.block_data  = block_q;
  assign bus_if.block_last  = block_last_q;
  assign busy_o             = busy_q;
  assign done_o             = done_q;

endmodule

// File: doc/sha256_block_padder.md
Name: sha256_block_padder

Overview:
- Upstream feeder for the SHA-256 compression stage.
- Reads a byte-sized message from word-addressed memory and applies SHA-256 padding on the fly: 0x80 delimiter, zero fill, 64-bit big-endian bit length.
- Presents one 512-bit block at a time on a valid/ready handshake, so the compression stage only ever sees complete padded blocks.

Parameters:
- READ_LAT, 2, clock edges from the edge that updates mem_addr to the edge that samples mem_read_data (range 1..4).
- ADDR_W, 16, mem_addr width.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled in IDLE only
- message_addr  in  32  word address of message word 0; low ADDR_W bits used
- size  in  32  message length in bytes
- mem_addr  out  ADDR_W  read word address
- mem_read_data  in  32  read data, big-endian (byte 0 in [31:24])
- block_valid  out  1  block_data holds a complete padded block
- block_ready  in  1  consumer accepts the block
- block_data  out  512  word 0 in [511:480] … word 15 in [31:0]
- block_last  out  1  qualifies block_valid: final block of the message
- busy  out  1  high from the accepted start until done
- done  out  1  one-cycle pulse after the final block is accepted

Behaviour:
- Reset (async, any state): state=IDLE; block_valid=0, block_last=0, busy=0, done=0, mem_addr=0, block_data=0, all counters=0.
- Derived values, latched at start:
  - nblocks = (size+72)/64, integer divide.
  - lenbits = {size[31:29], size[28:0], 3'b000} as 64 bits.
  - rd_words = ceil(size/4).
- Word k of the message (global index k = 16·blk + i):
  - 4k+4 <= size: mem word as read.
  - 4k < size < 4k+4, with r = size%4: keep the top r bytes of mem word, set byte r to 0x80, zero the remaining bytes.
    - r=1: data&FF000000|00800000
    - r=2: data&FFFF0000|00008000
    - r=3: data&FFFFFF00|00000080
  - 4k == size: 0x80000000, no memory read.
  - Otherwise 0x00000000, except in the final block: word 14 = lenbits[63:32], word 15 = lenbits[31:0].
  - Memory is read only for k < rd_words.
- States:
  - IDLE: when start=1, latch inputs, set busy, go to FILL.
  - FILL:
    - Issue addresses message_addr+k back-to-back, one per cycle, while k < rd_words and words of the current block remain.
    - Use an internal READ_LAT-deep tag pipeline (word slot i plus mask kind) to write returning data into slot i.
    - Write non-memory slots directly.
    - Go to PRESENT on the cycle after all 16 slots are written.
  - PRESENT:
    - block_valid=1; block_last=(blk==nblocks-1).
    - block_data and block_last are held stable and no mem_addr change occurs while block_ready=0.
    - Handshake on valid&ready:
      - if not last, blk+1 and go to FILL;
      - if last, go to DONE.
    - block_valid drops the cycle after acceptance.
  - DONE: done=1 for one cycle, busy=0, then IDLE.
- FILL latency:
  - Memory-backed block: PRESENT is entered 16+READ_LAT+1 cycles after FILL entry.
  - Pure pad block: 17 cycles.
- Boundaries:
  - start while busy: ignored.
  - size=0: one block.
  - size%64 in 56..63: an extra block carrying only the length.
  - mem_addr wraps modulo 2^ADDR_W.
  - block_ready high outside PRESENT: ignored.
  - reset_n low mid-FILL or mid-PRESENT: immediate return to reset values; in-flight read tags are discarded.

Optional Feature:
- Macro SHA256_PAD_BYTESWAP_EN.
- Defined: mem_read_data is byte-swapped ({[7:0],[15:8],[23:16],[31:24]}) before masking and padding, for little-endian message storage.
- Undefined: data is used as read; no swap logic is present.

Test Plan:
- size=3, mem[0]=0x61626364 -> one block:
  - word0=0x61626380, words1–14=0, word15=0x00000018, block_last=1
  - done pulses one cycle after acceptance.
- size=0 -> no mem reads; single block with word0=0x80000000, words1–15=0, block_last=1.
- size=56, mem words=0x00000001..0x0000000E -> two blocks:
  - block0 words0–13=mem, word14=0x80000000, word15=0, block_last=0
  - block1 words0–14=0, word15=0x000001C0, block_last=1
- size=64 -> two blocks:
  - block0 = 16 mem words
  - block1 word0=0x80000000, word15=0x00000200
  - exactly 16 distinct mem_addr values issued (message_addr..+15).
- block_ready held low 10 cycles in PRESENT, start pulsed meanwhile -> block_data/mem_addr stable, start ignored, busy=1; block accepted on first ready cycle.
- reset_n low for 1 cycle mid-FILL (size=100) -> outputs at reset values immediately; new start with size=3 then produces exactly the size=3 block above.
